// File: rtl/dnn_pkg.sv
// Shared constants, element type and loader FSM encoding for the DNN input path.
package dnn_pkg;

  localparam int INPUT_SIZE = 784;
  localparam int PIXEL_W    = 8;
  localparam int DATA_W     = 16;
  localparam int PIX_SHIFT  = 0;

  typedef logic signed [DATA_W-1:0] fixed_t;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/pixel_to_fixed.sv
// Converts an unsigned pixel to a non-negative signed fixed-point element:
// zero-extend, shift left, saturate at the largest positive value.
module pixel_to_fixed #(
  parameter int PIXEL_W   = 8,
  parameter int DATA_W    = 16,
  parameter int PIX_SHIFT = 0
) (
  input  logic [PIXEL_W-1:0] pixel,
  output logic [DATA_W-1:0]  elem
);

  localparam int WIDE_W = PIXEL_W + PIX_SHIFT;
  localparam int CMP_W  = (WIDE_W > DATA_W) ? WIDE_W : DATA_W;
  localparam logic [CMP_W-1:0] MAX_POS = {{(CMP_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  logic [CMP_W-1:0] shifted_s;

  // shift and clamp to 2^(DATA_W-1)-1
  always_comb begin
    shifted_s = CMP_W'(pixel) << PIX_SHIFT;
    if (shifted_s > MAX_POS) begin
      elem = MAX_POS[DATA_W-1:0];
    end else begin
      elem = shifted_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/pixel_frame_loader.sv
// Collects one frame of pixels into the classifier input vector, launches the
// classifier with a single start pulse and back-pressures until it reports done.
module pixel_frame_loader #(
  parameter int INPUT_SIZE = dnn_pkg::INPUT_SIZE,
  parameter int PIXEL_W    = dnn_pkg::PIXEL_W,
  parameter int DATA_W     = dnn_pkg::DATA_W,
  parameter int PIX_SHIFT  = dnn_pkg::PIX_SHIFT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [PIXEL_W-1:0]                s_pixel,
  input  logic                              s_last,
  input  logic                              dnn_done,
  output logic [INPUT_SIZE-1:0][DATA_W-1:0] input_vector,
  output logic                              start,
  output logic                              busy,
  output logic                              frame_err
);

  import dnn_pkg::*;

  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

  loader_state_t                     state_q, state_d;
  logic [IDX_W-1:0]                  index_q, index_d;
  logic [INPUT_SIZE-1:0][DATA_W-1:0] vec_q, vec_d;
  logic                              start_q, start_d;
  logic                              busy_q, busy_d;
  logic                              frame_err_q, frame_err_d;
  logic                              done_q;
  logic [DATA_W-1:0]                 elem_s;
  logic                              xfer_s;

  pixel_to_fixed #(
    .PIXEL_W  (PIXEL_W),
    .DATA_W   (DATA_W),
    .PIX_SHIFT(PIX_SHIFT)
  ) u_conv (
    .pixel(s_pixel),
    .elem (elem_s)
  );

  assign s_ready      = (state_q == LOAD);
  assign xfer_s       = s_valid & s_ready;
  assign input_vector = vec_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;

  // next-state, index and vector write logic
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    vec_d       = vec_q;
    frame_err_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (xfer_s) begin
          vec_d[index_q] = elem_s;
          if (index_q == LAST_IDX) begin
            // the pixel count decides the frame end; a missing last is only flagged
            index_d     = '0;
            state_d     = LAUNCH;
            frame_err_d = ~s_last;
          end else if (s_last) begin
            index_d     = '0;
            frame_err_d = 1'b1;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // only a fresh rising edge releases, so a stale done level is ignored
        if (dnn_done && !done_q) begin
          state_d = LOAD;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = LOAD;
        index_d = '0;
      end
    endcase
    start_d = (state_d == LAUNCH);
    busy_d  = (state_d != LOAD);
  end

  // state, counter, vector and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      index_q     <= '0;
      vec_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      vec_q       <= vec_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      done_q      <= dnn_done;
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader with a 4-pixel frame, unshifted and shifted-by-8 variants.
module tb_pixel_frame_loader;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic [7:0]        s_pixel;
  logic              s_last;
  logic              dnn_done;
  logic              s_ready, start, busy, frame_err;
  logic              s_ready_b, start_b, busy_b, frame_err_b;
  logic [3:0][15:0]  input_vector;
  logic [3:0][15:0]  input_vector_b;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int double_start = 0;
  logic start_prev = 1'b0;

  pixel_frame_loader #(.INPUT_SIZE(4), .PIXEL_W(8), .DATA_W(16), .PIX_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .s_last(s_last), .dnn_done(dnn_done), .input_vector(input_vector), .start(start),
    .busy(busy), .frame_err(frame_err)
  );

  pixel_frame_loader #(.INPUT_SIZE(4), .PIXEL_W(8), .DATA_W(16), .PIX_SHIFT(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_pixel(s_pixel),
    .s_last(s_last), .dnn_done(dnn_done), .input_vector(input_vector_b), .start(start_b),
    .busy(busy_b), .frame_err(frame_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start) start_cnt <= start_cnt + 1;
    if (start && start_prev) double_start <= double_start + 1;
    start_prev <= start;
  end

  function automatic logic [63:0] vec4(input logic [15:0] e0, input logic [15:0] e1,
                                       input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic push(input logic [7:0] pix, input logic last, input int gap);
    int n;
    n = 0;
    s_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_pixel = pix; s_last = last;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL push_timeout: waited %0d cycles, required < 50", n);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic release_done(input string tag);
    dnn_done = 1'b0;
    @(posedge clk); #1;
    dnn_done = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release: busy=%b s_ready=%b, required 0 1", tag, busy, s_ready);
    end
    dnn_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_pixel = 8'd0; s_last = 1'b0; dnn_done = 1'b0;
    #12;
    checks++;
    if (input_vector !== 64'd0 || start !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 ||
        s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: vec=%h start=%b busy=%b err=%b rdy=%b, required 0 0 0 0 1",
               input_vector, start, busy, frame_err, s_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int base;
    base = start_cnt;
    push(8'd10, 1'b0, 0); push(8'd20, 1'b0, 0); push(8'd30, 1'b0, 0); push(8'd255, 1'b1, 0);
    checks++;
    if (start !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_launch: start=%b busy=%b rdy=%b err=%b, required 1 1 0 0",
               start, busy, s_ready, frame_err);
    end
    checks++;
    if (input_vector !== vec4(16'd10, 16'd20, 16'd30, 16'd255)) begin
      errors++; $display("FAIL basic_vec: got %h", input_vector);
    end
    @(posedge clk); #1;
    checks++;
    if (start !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_wait: start=%b busy=%b, required 0 1", start, busy);
    end
    release_done("basic");
    checks++;
    if (start_cnt - base !== 1) begin
      errors++; $display("FAIL basic_start_cnt: got %0d required 1", start_cnt - base);
    end
  endtask

  task automatic test_gaps_done();
    int base;
    base = start_cnt;
    dnn_done = 1'b1;
    push(8'd5, 1'b0, 2); push(8'd6, 1'b0, 3); push(8'd7, 1'b0, 1); push(8'd8, 1'b1, 2);
    checks++;
    if (start !== 1'b1) begin
      errors++; $display("FAIL gaps_start: got %b required 1", start);
    end
    s_valid = 1'b1; s_pixel = 8'd99; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL stale_done: busy=%b rdy=%b, required 1 0", busy, s_ready);
    end
    checks++;
    if (input_vector !== vec4(16'd5, 16'd6, 16'd7, 16'd8)) begin
      errors++; $display("FAIL held_vec: got %h", input_vector);
    end
    dnn_done = 1'b0;
    @(posedge clk); #1;
    dnn_done = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL gaps_release: busy=%b rdy=%b, required 0 1", busy, s_ready);
    end
    dnn_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (start_cnt - base !== 1 || double_start !== 0) begin
      errors++; $display("FAIL gaps_start_cnt: got %0d dbl %0d required 1 0",
                         start_cnt - base, double_start);
    end
  endtask

  task automatic test_early_last();
    int base;
    base = start_cnt;
    push(8'd1, 1'b0, 0); push(8'd2, 1'b1, 0);
    checks++;
    if (frame_err !== 1'b1 || start !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL early_err: err=%b start=%b rdy=%b, required 1 0 1",
                         frame_err, start, s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_err !== 1'b0 || start_cnt - base !== 0) begin
      errors++; $display("FAIL early_pulse: err=%b starts=%0d, required 0 0",
                         frame_err, start_cnt - base);
    end
    push(8'd1, 1'b0, 0); push(8'd2, 1'b0, 0); push(8'd3, 1'b0, 0); push(8'd4, 1'b1, 0);
    checks++;
    if (start !== 1'b1 || frame_err !== 1'b0 ||
        input_vector !== vec4(16'd1, 16'd2, 16'd3, 16'd4)) begin
      errors++; $display("FAIL early_reload: start=%b err=%b vec=%h", start, frame_err, input_vector);
    end
    release_done("early");
  endtask

  task automatic test_no_last();
    push(8'd11, 1'b0, 0); push(8'd12, 1'b0, 0); push(8'd13, 1'b0, 0); push(8'd14, 1'b0, 0);
    checks++;
    if (start !== 1'b1 || frame_err !== 1'b1 ||
        input_vector !== vec4(16'd11, 16'd12, 16'd13, 16'd14)) begin
      errors++; $display("FAIL no_last: start=%b err=%b vec=%h, required 1 1", start, frame_err,
                         input_vector);
    end
    release_done("no_last");
  endtask

  task automatic test_saturation();
    push(8'd200, 1'b0, 0); push(8'd100, 1'b0, 0); push(8'd0, 1'b0, 0); push(8'd255, 1'b1, 0);
    checks++;
    if (input_vector !== vec4(16'd200, 16'd100, 16'd0, 16'd255)) begin
      errors++; $display("FAIL sat_shift0: got %h", input_vector);
    end
    checks++;
    if (input_vector_b !== vec4(16'd32767, 16'd25600, 16'd0, 16'd32767) || start_b !== 1'b1 ||
        busy_b !== 1'b1 || frame_err_b !== 1'b0) begin
      errors++; $display("FAIL sat_shift8: vec=%h start=%b busy=%b err=%b", input_vector_b,
                         start_b, busy_b, frame_err_b);
    end
    release_done("sat");
    checks++;
    if (busy_b !== 1'b0 || s_ready_b !== 1'b1) begin
      errors++; $display("FAIL sat_release: busy=%b rdy=%b, required 0 1", busy_b, s_ready_b);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = start_cnt;
    push(8'd7, 1'b0, 0); push(8'd8, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (input_vector !== 64'd0 || busy !== 1'b0 || start !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rst_load: vec=%h busy=%b start=%b err=%b", input_vector, busy,
                         start, frame_err);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1 || start_cnt - base !== 0) begin
      errors++; $display("FAIL rst_load_rel: rdy=%b starts=%0d, required 1 0", s_ready,
                         start_cnt - base);
    end
    push(8'd1, 1'b0, 0); push(8'd2, 1'b0, 0); push(8'd3, 1'b0, 0); push(8'd4, 1'b1, 0);
    checks++;
    if (start !== 1'b1 || input_vector !== vec4(16'd1, 16'd2, 16'd3, 16'd4)) begin
      errors++; $display("FAIL rst_index: start=%b vec=%h", start, input_vector);
    end
    base = start_cnt + 1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || start !== 1'b0 || input_vector !== 64'd0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wait: busy=%b start=%b rdy=%b vec=%h", busy, start, s_ready,
                         input_vector);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0 || start_cnt !== base) begin
      errors++; $display("FAIL rst_wait_rel: busy=%b starts=%0d, required 0 %0d", busy,
                         start_cnt, base);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps_done();
    test_early_last();
    test_no_last();
    test_saturation();
    test_reset_mid();
    checks++;
    if (double_start !== 0) begin
      errors++; $display("FAIL double_start: got %0d required 0", double_start);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
Upstream feeder for the DNN classifier top. It accepts a valid/ready stream of 8-bit grayscale pixels and converts each to signed 16-bit fixed point. It assembles one full frame into the INPUT_SIZE-entry input vector, then pulses start. The vector is held stable and new pixels are back-pressured until the classifier reports done.

Parameters:
INPUT_SIZE, 784, pixels per frame (28x28); must equal the classifier INPUT_SIZE
PIXEL_W, 8, incoming pixel width (unsigned)
DATA_W, 16, output element width (signed)
PIX_SHIFT, 0, left shift applied to the zero-extended pixel before saturation

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  pixel stream valid
s_ready  output  1  pixel stream ready
s_pixel  input  PIXEL_W  unsigned pixel value
s_last  input  1  marks final pixel of a frame
dnn_done  input  1  classifier done level (high once result valid)
input_vector  output  DATA_W x INPUT_SIZE  signed frame vector to the classifier
start  output  1  one-cycle pulse launching the classifier
busy  output  1  high from frame launch until classifier done
frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Reset (async, rst_n=0): FSM=LOAD, index=0, all input_vector entries=0, start=0, busy=0, frame_err=0, done_q=0. s_ready is combinational from state, so it is 1 immediately after reset release.
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Conversion: elem = zero_extend(s_pixel) << PIX_SHIFT. If the result exceeds 2^(DATA_W-1)-1, it saturates to 32767. Elements are never negative.
- FSM states: LOAD, LAUNCH, WAIT_DONE.
- LOAD state:
  - s_ready=1. A transfer occurs when s_valid and s_ready are both 1.
  - Each transfer writes input_vector[index] and increments index (width $clog2(INPUT_SIZE)).
- Early last: a transfer with s_last=1 and index<INPUT_SIZE-1 pulses frame_err the next cycle. index returns to 0, the frame is dropped, and the FSM stays in LOAD. Stale entries are left unchanged and are overwritten by the next frame.
- Final pixel: a transfer with index==INPUT_SIZE-1 moves the FSM to LAUNCH and sets index=0.
  - If s_last=0 on that transfer, frame_err pulses and the frame is still launched. The count is authoritative.
- LAUNCH state: lasts 1 cycle. start=1, s_ready=0, busy=1. Then goes to WAIT_DONE.
  - Latency: start is asserted in the cycle after the final pixel handshake.
- WAIT_DONE state:
  - s_ready=0, busy=1.
  - done_q is a registered copy of dnn_done.
  - Exit on a rising edge (dnn_done=1 and done_q=0) to LOAD, with busy=0 in the next cycle. A done level left over from the previous frame is therefore ignored.
- input_vector is stable from the LAUNCH cycle until exit from WAIT_DONE; no writes occur outside LOAD.
- s_valid while s_ready=0: no transfer occurs; the upstream source must hold its data.
- Reset mid-frame or mid-compute: immediate return to the reset state. The partial frame is lost and no start is issued.
- start is never asserted for two consecutive cycles. At most one start is issued per accepted frame.

Decomposition:
- dnn_pkg holds:
  - INPUT_SIZE, DATA_W, PIXEL_W constants
  - typedef logic signed [DATA_W-1:0] fixed_t
  - enum loader_state_t {LOAD, LAUNCH, WAIT_DONE}
- One combinational sub-module, pixel_to_fixed: shift plus saturation, parameterised by PIXEL_W, DATA_W, PIX_SHIFT.
- FSM, counter and vector storage stay in pixel_frame_loader.

Test Plan:
1. INPUT_SIZE=4; stream pixels 10,20,30,255 with s_last on the 4th -> input_vector={10,20,30,255}, start pulses 1 cycle after the 4th handshake, busy=1, s_ready=0.
2. Same frame with s_valid gaps and held data; pulse dnn_done high at cycle+5 -> exactly one start; s_ready returns 1 and busy 0 one cycle after the dnn_done rising edge; a constant-high dnn_done at entry does not release.
3. INPUT_SIZE=4; s_last on 2nd pixel -> frame_err pulse, no start, next 4-pixel frame 1,2,3,4 loads correctly and launches.
4. INPUT_SIZE=4; no s_last on 4th pixel -> frame_err pulse and start both asserted, vector correct.
5. PIX_SHIFT=8, pixel 200 -> element saturates to 32767; pixel 100 -> 25600.
6. Assert rst_n=0 after 2 pixels and again during WAIT_DONE -> all outputs 0 asynchronously, s_ready=1 after release, no start.
